// File: rtl/octree_axil_bridge.sv
// AXI4-Lite slave that serializes CPU accesses into one-cycle mem_req transfers for the Octree CSR/SRAM wrapper.
// Optional address decoding / SLVERR generation: define OCTREE_BRIDGE_ADDR_CHECK_EN.
module octree_axil_bridge #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [1:0]              bresp_o,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    mem_req_o,
    output logic                    mem_write_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_WAIT,
        RD_RESP,
        ERR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                    r_state;
    logic                      r_last_wr;
    logic                      r_is_wr;
    logic [2:0]                r_cnt;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic [DATA_WIDTH/8-1:0]   r_mem_be;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic                      r_rvalid;
    logic [1:0]                r_rresp;
    logic [DATA_WIDTH-1:0]     r_rdata;

    logic w_idle;
    logic w_wr_elig;
    logic w_take_wr;
    logic w_take_rd;
    logic w_wr_err;
    logic w_rd_err;

    // Ready is gated by reset so no handshake can be advertised while the bridge is held in reset.
    assign w_idle    = (r_state == IDLE) && rstn_i;
    assign w_wr_elig = awvalid_i && wvalid_i;
    assign w_take_wr = w_idle && w_wr_elig && (!arvalid_i || !r_last_wr);
    assign w_take_rd = w_idle && arvalid_i && !(w_wr_elig && !r_last_wr);

`ifdef OCTREE_BRIDGE_ADDR_CHECK_EN
    function automatic logic f_in_map(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(64'h6000_0000)) ||
               (a == ADDR_WIDTH'(64'h6001_0000)) ||
               (a == ADDR_WIDTH'(64'h600F_0000)) ||
               ((a >= ADDR_WIDTH'(64'h6010_0000)) && (a <= ADDR_WIDTH'(64'h6010_1FFF))) ||
               ((a >= ADDR_WIDTH'(64'h6020_0000)) && (a <= ADDR_WIDTH'(64'h6020_1FFF)));
    endfunction

    assign w_wr_err = (awaddr_i[2:0] != 3'b000) || !f_in_map(awaddr_i) ||
                      (awaddr_i == ADDR_WIDTH'(64'h600F_0000));
    assign w_rd_err = (araddr_i[2:0] != 3'b000) || !f_in_map(araddr_i);
`else
    assign w_wr_err = 1'b0;
    assign w_rd_err = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= IDLE;
            r_last_wr   <= 1'b0;
            r_is_wr     <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_bvalid    <= 1'b0;
            r_bresp     <= '0;
            r_rvalid    <= 1'b0;
            r_rresp     <= '0;
            r_rdata     <= '0;
        end else begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take_wr) begin
                        r_last_wr <= 1'b1;
                        r_is_wr   <= 1'b1;
                        if (w_wr_err) begin
                            r_state  <= ERR_RESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_SLVERR;
                        end else begin
                            r_state     <= WR_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= awaddr_i;
                            r_mem_wdata <= wdata_i;
                            r_mem_be    <= wstrb_i;
                        end
                    end else if (w_take_rd) begin
                        r_last_wr <= 1'b0;
                        r_is_wr   <= 1'b0;
                        if (w_rd_err) begin
                            r_state  <= ERR_RESP;
                            r_rvalid <= 1'b1;
                            r_rresp  <= RESP_SLVERR;
                            r_rdata  <= '0;
                        end else begin
                            r_state    <= RD_REQ;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= araddr_i;
                            r_mem_be   <= '1;
                        end
                    end
                end
                WR_REQ: begin
                    r_state  <= WR_RESP;
                    r_bvalid <= 1'b1;
                    r_bresp  <= RESP_OKAY;
                end
                WR_RESP: begin
                    if (bready_i) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                RD_REQ: begin
                    r_cnt   <= 3'(RD_LATENCY);
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Counter value 1 marks the cycle in which the wrapper's read data is valid.
                    if (r_cnt == 3'd1) begin
                        r_rdata  <= mem_rdata_i;
                        r_rvalid <= 1'b1;
                        r_rresp  <= RESP_OKAY;
                        r_state  <= RD_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RD_RESP: begin
                    if (rready_i) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                ERR_RESP: begin
                    if (r_is_wr ? bready_i : rready_i) begin
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign awready_o      = w_take_wr;
    assign wready_o       = w_take_wr;
    assign arready_o      = w_take_rd;
    assign bvalid_o       = r_bvalid;
    assign bresp_o        = r_bresp;
    assign rvalid_o       = r_rvalid;
    assign rresp_o        = r_rresp;
    assign rdata_o        = r_rdata;
    assign mem_req_o      = r_mem_req;
    assign mem_write_en_o = r_mem_we;
    assign mem_byte_en_o  = r_mem_be;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;

endmodule

// File: tb/tb_octree_axil_bridge.sv
// Bench for octree_axil_bridge: timeline model of the bridge plus a wrapper memory model, checked every cycle.
// Honours OCTREE_BRIDGE_ADDR_CHECK_EN when the design is built with it.
module tb_octree_axil_bridge;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned L  = 2;

`ifdef OCTREE_BRIDGE_ADDR_CHECK_EN
    localparam bit ACHK = 1'b1;
`else
    localparam bit ACHK = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          awvalid_i, awready_o;
    logic [AW-1:0] awaddr_i;
    logic          wvalid_i, wready_o;
    logic [DW-1:0] wdata_i;
    logic [7:0]    wstrb_i;
    logic          bvalid_o, bready_i;
    logic [1:0]    bresp_o;
    logic          arvalid_i, arready_o;
    logic [AW-1:0] araddr_i;
    logic          rvalid_o, rready_i;
    logic [DW-1:0] rdata_o;
    logic [1:0]    rresp_o;
    logic          mem_req_o, mem_write_en_o;
    logic [7:0]    mem_byte_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    octree_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .mem_req_o(mem_req_o), .mem_write_en_o(mem_write_en_o), .mem_byte_en_o(mem_byte_en_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Wrapper model: sparse memory, read data presented only in the cycle it is due.
    logic [63:0] mem [logic [63:0]];
    int          rd_due[$];
    logic [63:0] rd_adr[$];

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[31:0], ~a[31:0]};
    endfunction

    always @(posedge clk_i) begin
        #1;
        cyc++;
        mem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
        if (rd_due.size() > 0 && rd_due[0] == cyc) begin
            mem_rdata_i = mem_fn(rd_adr[0]);
            void'(rd_due.pop_front());
            void'(rd_adr.pop_front());
        end
    end

    always @(negedge clk_i) begin
        logic [63:0] v;
        if (!rstn_i) begin
            rd_due.delete();
            rd_adr.delete();
        end else if (mem_req_o) begin
            if (mem_write_en_o) begin
                v = mem_fn(mem_addr_o);
                for (int b = 0; b < 8; b++)
                    if (mem_byte_en_o[b]) v[8*b +: 8] = mem_wdata_o[8*b +: 8];
                mem[mem_addr_o] = v;
            end else begin
                rd_due.push_back(cyc + int'(L));
                rd_adr.push_back(mem_addr_o);
            end
        end
    end

    function automatic bit addr_err(input logic [63:0] a, input bit wr);
        bit hit;
        if (!ACHK) return 1'b0;
        hit = (a == 64'h6000_0000) || (a == 64'h6001_0000) || (a == 64'h600F_0000) ||
              (a >= 64'h6010_0000 && a <= 64'h6010_1FFF) ||
              (a >= 64'h6020_0000 && a <= 64'h6020_1FFF);
        if (wr && a == 64'h600F_0000) return 1'b1;
        return (a[2:0] != 3'b000) || !hit;
    endfunction

    // Bridge model: one transaction at a time, described by its acceptance cycle.
    bit          m_busy, m_wr, m_err, m_last_wr;
    int          m_acc;
    logic [63:0] m_taddr, m_twdata;
    logic [7:0]  m_tstrb;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_be;
    logic [1:0]  m_bresp, m_rresp;

    always @(negedge clk_i) begin
        bit e_req, e_we, e_bv, e_rv, e_awr, e_arr, was_busy, done;
        int t, rs;
        e_req = 0; e_we = 0; e_bv = 0; e_rv = 0; e_awr = 0; e_arr = 0; done = 0;
        was_busy = 0;
        if (!rstn_i) begin
            m_busy = 0; m_last_wr = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0; m_bresp = '0; m_rresp = '0;
        end else if (m_busy) begin
            was_busy = 1;
            t  = cyc - m_acc;
            rs = m_err ? 1 : (m_wr ? 2 : 2 + int'(L));
            if (t == 1 && !m_err) begin
                e_req  = 1;
                e_we   = m_wr;
                m_addr = m_taddr;
                if (m_wr) begin m_wdata = m_twdata; m_be = m_tstrb; end
                else m_be = 8'hFF;
            end
            if (t == rs) begin
                if (m_wr) m_bresp = m_err ? 2'b10 : 2'b00;
                else begin
                    m_rresp = m_err ? 2'b10 : 2'b00;
                    m_rdata = m_err ? 64'h0 : mem_fn(m_taddr);
                end
            end
            if (t >= rs) begin
                if (m_wr) e_bv = 1; else e_rv = 1;
                done = m_wr ? bready_i : rready_i;
            end
        end else begin
            if (awvalid_i && wvalid_i && (!arvalid_i || !m_last_wr)) begin
                e_awr = 1; m_busy = 1; m_wr = 1; m_acc = cyc; m_last_wr = 1;
                m_taddr = awaddr_i; m_twdata = wdata_i; m_tstrb = wstrb_i;
                m_err = addr_err(awaddr_i, 1'b1);
            end else if (arvalid_i) begin
                e_arr = 1; m_busy = 1; m_wr = 0; m_acc = cyc; m_last_wr = 0;
                m_taddr = araddr_i;
                m_err = addr_err(araddr_i, 1'b0);
            end
        end
        chk("awready", awready_o, e_awr);
        chk("wready", wready_o, e_awr);
        chk("arready", arready_o, e_arr);
        chk("mem_req", mem_req_o, e_req);
        chk("mem_we", mem_write_en_o, e_we);
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_wdata", mem_wdata_o, m_wdata);
        chk("mem_be", mem_byte_en_o, m_be);
        chk("bvalid", bvalid_o, e_bv);
        chk("bresp", bresp_o, m_bresp);
        chk("rvalid", rvalid_o, e_rv);
        chk("rresp", rresp_o, m_rresp);
        chk("rdata", rdata_o, m_rdata);
        if (was_busy && done) m_busy = 0;
    end

    localparam int SIG_AWR = 0, SIG_ARR = 1, SIG_BV = 2, SIG_RV = 3;

    function automatic logic sig(input int which);
        case (which)
            SIG_AWR: return awready_o;
            SIG_ARR: return arready_o;
            SIG_BV:  return bvalid_o;
            default: return rvalid_o;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string nm);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (sig(which)) return;
        end
        total++;
        bad++;
        $display("FAIL %s timeout waiting got=0 exp=1", nm);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        awvalid_i = 0; wvalid_i = 0; arvalid_i = 0; bready_i = 0; rready_i = 0;
        awaddr_i = '0; wdata_i = '0; wstrb_i = '0; araddr_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    int n, nreq;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
        do_reset();
        @(negedge clk_i);
        chk("rst_bvalid", bvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);

        // Full-width write
        step();
        awaddr_i = 64'h6000_0000; wdata_i = 64'h1234_5678_9ABC_DEF0; wstrb_i = 8'hFF;
        awvalid_i = 1; wvalid_i = 1; bready_i = 1;
        wait_sig(SIG_AWR, "wr_accept");
        chk("wr_wready_same", wready_o, 1);
        step();
        awvalid_i = 0; wvalid_i = 0;
        @(negedge clk_i);
        chk("wr_req", mem_req_o, 1);
        chk("wr_we", mem_write_en_o, 1);
        chk("wr_addr", mem_addr_o, 64'h6000_0000);
        chk("wr_data", mem_wdata_o, 64'h1234_5678_9ABC_DEF0);
        chk("wr_be", mem_byte_en_o, 8'hFF);
        @(negedge clk_i);
        chk("wr_req_off", mem_req_o, 0);
        chk("wr_bvalid", bvalid_o, 1);
        chk("wr_bresp", bresp_o, 2'b00);
        step();
        bready_i = 0;
        repeat (2) step();

        // Read with latency and back-pressure
        mem[64'h6010_0008] = 64'hA5A5_0000_0000_0001;
        araddr_i = 64'h6010_0008; arvalid_i = 1; rready_i = 0;
        wait_sig(SIG_ARR, "rd_accept");
        step();
        arvalid_i = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            n++;
            if (rvalid_o) break;
        end
        chk("rd_latency", n, 4);
        chk("rd_data", rdata_o, 64'hA5A5_0000_0000_0001);
        chk("rd_resp", rresp_o, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rd_hold_valid", rvalid_o, 1);
            chk("rd_hold_data", rdata_o, 64'hA5A5_0000_0000_0001);
        end
        step();
        rready_i = 1;
        step();
        rready_i = 0;
        repeat (2) step();

        // Round-robin arbitration from reset
        do_reset();
        awaddr_i = 64'h6001_0000; wdata_i = 64'h0000_0000_CAFE_F00D; wstrb_i = 8'h0F;
        araddr_i = 64'h6001_0000;
        awvalid_i = 1; wvalid_i = 1; arvalid_i = 1; bready_i = 1; rready_i = 1;
        @(negedge clk_i);
        chk("arb1_aw_wins", awready_o, 1);
        chk("arb1_ar_waits", arready_o, 0);
        step();
        awvalid_i = 0; wvalid_i = 0;
        wait_sig(SIG_ARR, "arb1_rd_accept");
        step();
        arvalid_i = 0;
        repeat (8) step();
        // Lone write leaves the write as most recent winner, so the next pair favours the read.
        awaddr_i = 64'h6000_0000; wdata_i = 64'h1111_2222_3333_4444; wstrb_i = 8'hF0;
        awvalid_i = 1; wvalid_i = 1;
        wait_sig(SIG_AWR, "arb_lone_wr");
        step();
        awvalid_i = 0; wvalid_i = 0;
        repeat (6) step();
        araddr_i = 64'h6000_0000;
        awaddr_i = 64'h6001_0000; wdata_i = 64'h5555_6666_7777_8888; wstrb_i = 8'hFF;
        awvalid_i = 1; wvalid_i = 1; arvalid_i = 1;
        @(negedge clk_i);
        chk("arb2_ar_wins", arready_o, 1);
        chk("arb2_aw_waits", awready_o, 0);
        step();
        arvalid_i = 0;
        wait_sig(SIG_AWR, "arb2_wr_accept");
        step();
        awvalid_i = 0; wvalid_i = 0;
        repeat (8) step();

        // AW without W
        awaddr_i = 64'h6001_0000; wdata_i = 64'h0102_0304_0506_0708; wstrb_i = 8'h3C;
        awvalid_i = 1; wvalid_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("aw_only_ready", awready_o, 0);
            chk("aw_only_req", mem_req_o, 0);
        end
        step();
        wvalid_i = 1;
        @(negedge clk_i);
        chk("aw_w_awready", awready_o, 1);
        chk("aw_w_wready", wready_o, 1);
        step();
        awvalid_i = 0; wvalid_i = 0;
        repeat (6) step();

        // Out-of-map read and read-only write
        araddr_i = 64'h6030_0000; arvalid_i = 1;
        wait_sig(SIG_ARR, "bad_rd_accept");
        step();
        arvalid_i = 0;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (mem_req_o) nreq++;
            if (rvalid_o) break;
        end
        chk("bad_rd_reqs", nreq, ACHK ? 0 : 1);
        chk("bad_rd_resp", rresp_o, ACHK ? 2'b10 : 2'b00);
        repeat (3) step();
        awaddr_i = 64'h600F_0000; wdata_i = 64'hFFFF_0000_FFFF_0000; wstrb_i = 8'hFF;
        awvalid_i = 1; wvalid_i = 1;
        wait_sig(SIG_AWR, "bad_wr_accept");
        step();
        awvalid_i = 0; wvalid_i = 0;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (mem_req_o) nreq++;
            if (bvalid_o) break;
        end
        chk("bad_wr_reqs", nreq, ACHK ? 0 : 1);
        chk("bad_wr_resp", bresp_o, ACHK ? 2'b10 : 2'b00);
        repeat (3) step();

        // Reset during RD_WAIT
        araddr_i = 64'h6020_0010; arvalid_i = 1;
        wait_sig(SIG_ARR, "rst_rd_accept");
        step();
        arvalid_i = 0;
        @(negedge clk_i);
        chk("rst_rd_req", mem_req_o, 1);
        step();
        #2 rstn_i = 1'b0;
        #1;
        chk("rst_now_req", mem_req_o, 0);
        chk("rst_now_addr", mem_addr_o, 0);
        chk("rst_now_be", mem_byte_en_o, 0);
        chk("rst_now_rvalid", rvalid_o, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rst_no_rvalid", rvalid_o, 0);
        end
        step();
        rstn_i = 1'b1;
        araddr_i = 64'h6020_0010; arvalid_i = 1;
        wait_sig(SIG_ARR, "post_rst_accept");
        step();
        arvalid_i = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            n++;
            if (rvalid_o) break;
        end
        chk("post_rst_latency", n, 4);
        chk("post_rst_data", rdata_o, 64'h6020_0010_9FDF_FFEF);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
